// File: rtl/operand_fifo.sv
// operand_fifo: first-word-fall-through valid/ready operand buffer; in_* write side, out_* head side, count = stored words
module operand_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign in_ready = count != CNT_W'(DEPTH);
  assign out_valid = count != '0;
  assign out_data = mem[rd_ptr];
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk_i or negedge arst_n)
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
    end
endmodule

// File: tb/tb_operand_fifo.sv
// tb_operand_fifo: directed stimulus with a queue scoreboard and an independent output monitor
module tb_operand_fifo;
  logic clk_i, arst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] count;
  int checks = 0, failures = 0;
  logic [7:0] exp_q [$];
  operand_fifo dut (
    .clk_i(clk_i), .arst_n(arst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk_i)
    if (arst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", int'(out_data), -1);
      else chk("out_data", int'(out_data), int'(exp_q.pop_front()));
    end
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic push_word(input logic [7:0] w);
    in_data = w;
    in_valid = 1'b1;
    exp_q.push_back(w);
    step();
  endtask
  task automatic wait_empty(input string name);
    int n = 0;
    while (count != 0 && n < 20) begin
      step();
      n++;
    end
    chk(name, n < 20, 1);
  endtask
  initial begin
    arst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 8'h00;
    #2;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    step();
    arst_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    foreach (exp_q[i]) ;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    in_data = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("blocked_count", count, 4);
      chk("blocked_head", out_data, 8'h11);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("drain_count", count, 0);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_sb_empty", exp_q.size(), 0);
    out_ready = 1'b0;
    push_word(8'h61);
    push_word(8'h62);
    push_word(8'h63);
    push_word(8'h64);
    chk("full_count", count, 4);
    out_ready = 1'b1;
    push_word(8'h65);
    chk("full_pop_only_count", count, 3);
    chk("full_pop_in_ready", in_ready, 1);
    step();
    chk("push_pop_count", count, 3);
    in_valid = 1'b0;
    wait_empty("full_drain_timeout");
    chk("full_sb_empty", exp_q.size(), 0);
    for (int i = 0; i < 20; i++) begin
      push_word(8'(i));
      chk("stream_count_le1", count <= 1, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_count_end", count, 0);
    chk("stream_sb_empty", exp_q.size(), 0);
    out_ready = 1'b0;
    push_word(8'hB1);
    push_word(8'hB2);
    push_word(8'hB3);
    in_valid = 1'b0;
    chk("stall_count", count, 3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_out_data", out_data, 8'hB1);
      chk("stall_out_valid", out_valid, 1);
    end
    #1;
    arst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    #1;
    arst_n = 1'b1;
    step();
    out_ready = 1'b1;
    chk("after_rst_out_valid", out_valid, 0);
    push_word(8'hA5);
    in_valid = 1'b0;
    step();
    step();
    chk("after_rst_count", count, 0);
    chk("after_rst_sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
